// File: rtl/shift_tx_if.sv
// shift_tx_if: load handshake and serial output bundle for shift_tx.
// The master drives load_valid/load_data. The slave (shift_tx) drives the rest.
interface shift_tx_if #(
   parameter int WIDTH = 4
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  busy,
      input  done
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready,
      output sout,
      output sout_valid,
      output busy,
      output done
   );
endinterface

// File: rtl/shift_tx.sv
// shift_tx: parallel-to-serial transmitter with an IDLE / SHIFT / DONE FSM.
// A word is accepted in IDLE when load_valid is high. It is then shifted out
// one bit per cycle, in MSB-first or LSB-first order. A single-cycle DONE
// follows, and the FSM returns to IDLE.
// Optional feature: define SHIFT_TX_PARITY_EN to append one even-parity bit
// after the data bits. The parity bit is the XOR of the accepted word.
// All outputs are decoded from the state register. An asynchronous reset
// therefore forces them to their idle values at once.
module shift_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic     clk,
   input  logic     rst,   // asynchronous, active-low
   shift_tx_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 2);
`ifdef SHIFT_TX_PARITY_EN
   // The data bits use counts 0..WIDTH-1. Count WIDTH is the parity slot.
   localparam int LAST = WIDTH;
`else
   localparam int LAST = WIDTH - 1;
`endif
   localparam logic [CW-1:0] C_LAST = CW'(LAST);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_shift_next;
   logic             w_data_bit;
   logic             w_sout_bit;
   logic             w_accept;
   logic             w_load_ready;
   logic             w_sout;
   logic             w_sout_valid;
   logic             w_busy;
   logic             w_done;

   // The serial order only changes which end of the shift register is
   // presented and which way the register moves.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_data_bit   = r_shift[WIDTH-1];
         assign w_shift_next = r_shift << 1;
      end else begin : g_lsb
         assign w_data_bit   = r_shift[0];
         assign w_shift_next = r_shift >> 1;
      end
   endgenerate

`ifdef SHIFT_TX_PARITY_EN
   logic r_parity;

   // Capture the even parity of the accepted word so that later load_data changes cannot disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_parity <= ^bus.load_data;
      end
   end

   assign w_sout_bit = (r_cnt == CW'(WIDTH)) ? r_parity : w_data_bit;
`else
   assign w_sout_bit = w_data_bit;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and output decode. Every output is a function of state only.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_load_ready = 1'b0;
      w_sout       = 1'b0;
      w_sout_valid = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_load_ready = 1'b1;
            if (bus.load_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_sout_valid = 1'b1;
            w_busy       = 1'b1;
            w_sout       = w_sout_bit;
            if (r_cnt == C_LAST) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_busy       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Data path. Load and clear the counter on acceptance, then advance once per SHIFT cycle.
   // The counter holds at the last slot, so it cannot wrap within a word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_shift <= bus.load_data;
         r_cnt   <= '0;
      end else if (r_state == S_SHIFT) begin
         r_shift <= w_shift_next;
         if (r_cnt != C_LAST) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign bus.load_ready = w_load_ready;
   assign bus.sout       = w_sout;
   assign bus.sout_valid = w_sout_valid;
   assign bus.busy       = w_busy;
   assign bus.done       = w_done;

endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: scoreboard bench for shift_tx.
// Two instances share one stimulus stream: one is MSB-first and one is LSB-first.
// The reference model tracks acceptances and pushes the expected bit stream,
// followed by a done marker, into one queue per instance.
// A negedge monitor pops a queue entry whenever an instance shows sout_valid or done.
module tb_shift_tx;
   localparam int W = 4;
`ifdef SHIFT_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int DONE_MARK = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         lv  = 1'b0;
   logic [W-1:0] ld  = '0;

   int n_checks  = 0;
   int n_pass    = 0;
   int mcnt      = 0;   // cycles of SHIFT+DONE left in the model; 0 means idle
   int m_accepts = 0;
   int q0[$];           // MSB-first expected stream
   int q1[$];           // LSB-first expected stream

   shift_tx_if #(.WIDTH(W)) bus_m ();
   shift_tx_if #(.WIDTH(W)) bus_l ();

   assign bus_m.load_valid = lv;
   assign bus_m.load_data  = ld;
   assign bus_l.load_valid = lv;
   assign bus_l.load_data  = ld;

   shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
   shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: accept on any edge where the block is idle and load_valid is high.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcnt = 0;
         q0.delete();
         q1.delete();
      end else if (mcnt == 0) begin
         if (lv) begin
            for (int i = 0; i < W; i++) begin
               q0.push_back(int'((ld >> (W - 1 - i)) & 1));
               q1.push_back(int'((ld >> i) & 1));
            end
            if (P != 0) begin
               q0.push_back($countones(ld) % 2);
               q1.push_back($countones(ld) % 2);
            end
            q0.push_back(DONE_MARK);
            q1.push_back(DONE_MARK);
            mcnt = W + P + 1;
            m_accepts++;
            $display("tx %0d: accepted word 0x%h", m_accepts, ld);
         end
      end else begin
         mcnt--;
      end
   end

   task automatic check_dut(input int d, input logic sv, input logic so,
                            input logic dn, input logic rdy, input logic bsy);
      string tag;
      int    qs;
      int    e;
      int    obs;
      tag = (d == 0) ? "msb" : "lsb";
      qs  = (d == 0) ? q0.size() : q1.size();
      chk({tag, ".load_ready"}, int'(rdy), int'(mcnt == 0));
      chk({tag, ".busy"}, int'(bsy), int'(mcnt != 0));
      if (sv || dn) begin
         chk({tag, ".output_expected"}, int'(qs > 0), 1);
         if (qs > 0) begin
            e   = (d == 0) ? q0.pop_front() : q1.pop_front();
            obs = dn ? (sv ? 3 : DONE_MARK) : int'(so);
            chk({tag, ".stream_item"}, obs, e);
         end
      end else begin
         chk({tag, ".sout_idle"}, int'(so), 0);
      end
   endtask

   task automatic reset_checks();
      chk("msb.rst_sout",       int'(bus_m.sout), 0);
      chk("msb.rst_sout_valid", int'(bus_m.sout_valid), 0);
      chk("msb.rst_busy",       int'(bus_m.busy), 0);
      chk("msb.rst_done",       int'(bus_m.done), 0);
      chk("msb.rst_load_ready", int'(bus_m.load_ready), 1);
      chk("lsb.rst_sout",       int'(bus_l.sout), 0);
      chk("lsb.rst_sout_valid", int'(bus_l.sout_valid), 0);
      chk("lsb.rst_busy",       int'(bus_l.busy), 0);
      chk("lsb.rst_done",       int'(bus_l.done), 0);
      chk("lsb.rst_load_ready", int'(bus_l.load_ready), 1);
   endtask

   // Monitor: sample away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         check_dut(0, bus_m.sout_valid, bus_m.sout, bus_m.done, bus_m.load_ready, bus_m.busy);
         check_dut(1, bus_l.sout_valid, bus_l.sout, bus_l.done, bus_l.load_ready, bus_l.busy);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Present a word and hold it until the model has accepted it, within a bounded wait.
   task automatic send(input logic [W-1:0] w);
      int start;
      start = m_accepts;
      lv = 1'b1;
      ld = w;
      for (int i = 0; i < 40 && m_accepts == start; i++) step();
      chk("accept_within_bound", int'(m_accepts > start), 1);
      lv = 1'b0;
   endtask

   initial begin
      #2;
      reset_checks();
      step();
      rst = 1'b1;

      // Basic word, then a second word presented while the first is shifting.
      send(4'b1011);
      send(4'b0110);
      send(4'b0000);
      send(4'b1111);

      // Reset mid-word, after two bits have been shown.
      send(4'b1111);
      step();
      step();
      rst = 1'b0;
      #1;
      reset_checks();
      step();
      step();
      rst = 1'b1;
      send(4'b1001);

      // Randomized load_valid and load_data, including changes while busy.
      for (int c = 0; c < 400; c++) begin
         step();
         lv = 1'($urandom_range(0, 1));
         ld = W'($urandom);
      end
      lv = 1'b0;

      // Drain the scoreboard within a bound.
      for (int i = 0; i < 40 && (mcnt != 0 || q0.size() != 0 || q1.size() != 0); i++) step();
      @(negedge clk);
      #1;
      chk("msb.queue_drained", q0.size(), 0);
      chk("lsb.queue_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/shift_tx.md
SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 Parameter WIDTH, default 4, shall set the number of data bits per word.
REQ-002 Parameter MSB_FIRST, default 1, shall select serial order: 1 = MSB first, 0 = LSB first.
REQ-003 clk  input  1  shall be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  shall be the reset, asynchronous, active-low.
REQ-005 load_valid  input  1  shall flag that load_data holds a word to send.
REQ-006 load_data  input  WIDTH  shall carry the parallel word.
REQ-007 load_ready  output  1  shall indicate the block can accept a word.
REQ-008 sout  output  1  shall carry the serial bit stream.
REQ-009 sout_valid  output  1  shall mark cycles in which sout carries a data or parity bit.
REQ-010 busy  output  1  shall be high from word acceptance until the end of the DONE cycle.
REQ-011 done  output  1  shall pulse for one cycle after the last bit of a word.

Function
REQ-012 The FSM shall have three states: IDLE, SHIFT and DONE.
REQ-013 Transfers:
- A word shall be accepted on a rising edge where load_valid = 1 and load_ready = 1.
- load_ready shall be 1 only in IDLE.
REQ-014 On acceptance:
- load_data shall be captured into an internal shift register.
- The bit counter shall be cleared.
- The FSM shall enter SHIFT on the same edge.
REQ-015 SHIFT timing:
- In the first SHIFT cycle, sout shall present bit WIDTH-1 (MSB_FIRST = 1) or bit 0 (MSB_FIRST = 0).
- Each later cycle shall present the next bit.
- sout_valid shall be 1 throughout SHIFT.
REQ-016 SHIFT shall last exactly WIDTH cycles, plus one parity cycle when enabled per REQ-027; the FSM shall then enter DONE.
REQ-017 DONE shall last exactly one cycle:
- done = 1, busy = 1, sout_valid = 0, sout = 0, load_ready = 0.
- The FSM shall then return to IDLE.
REQ-018 In IDLE, sout, sout_valid, busy and done shall all be 0.
REQ-019 Changes on load_valid and load_data while not in IDLE shall not affect the word in flight.
REQ-020 Words shall not overlap.
- The minimum spacing between acceptances shall be WIDTH+2 cycles, or WIDTH+3 with parity.
- A word held valid through DONE shall be accepted on the first IDLE edge.
REQ-021 The bit counter shall be ceil(log2(WIDTH+2)) bits wide and shall never wrap within a word.

Reset
REQ-022 Assertion of rst = 0 shall immediately force IDLE, regardless of the clock.
REQ-023 On reset:
- sout, sout_valid, busy and done shall be 0, and load_ready shall be 1.
- The shift register and bit counter shall be 0.
REQ-024 Reset asserted mid-word shall abort the word; no done pulse shall be issued for it.
REQ-025 After rst deasserts, the first rising edge shall be able to accept a word.

Configuration
REQ-026 Macro SHIFT_TX_PARITY_EN shall control the parity feature.
REQ-027 With SHIFT_TX_PARITY_EN defined:
- One extra SHIFT cycle shall follow the data bits.
- In that cycle sout shall equal the XOR of the accepted word (even parity), with sout_valid = 1.
REQ-028 Without SHIFT_TX_PARITY_EN:
- SHIFT shall be exactly WIDTH cycles.
- No parity logic shall be synthesized.

Verification
REQ-029 Basic MSB-first: WIDTH = 4, MSB_FIRST = 1, parity off, accept 4'b1011.
- sout shall be 1,0,1,1 on the 4 cycles after acceptance, with sout_valid = 1.
- done = 1 on the 5th cycle.
- load_ready = 1 on the 6th cycle.
REQ-030 LSB-first: MSB_FIRST = 0, accept 4'b1011.
- sout shall be 1,1,0,1, then done.
REQ-031 Parity: SHIFT_TX_PARITY_EN defined, accept 4'b1011.
- sout shall be 1,0,1,1 then parity 1.
- done = 1 on the 6th cycle.
- Repeat with 4'b0110: parity bit shall be 0.
REQ-032 Load while busy: accept 4'b1011; during SHIFT, drive load_valid = 1 with 4'b0110.
- The stream shall remain 1,0,1,1.
- 4'b0110 shall be accepted on the first IDLE edge and yield 0,1,1,0.
REQ-033 Reset mid-word: accept 4'b1111, then pull rst low between clock edges after 2 bits.
- sout, sout_valid and busy shall drop to 0 and load_ready shall rise to 1 without waiting for a clock edge.
- No done pulse shall occur.
- After release, 4'b1001 shall transmit 1,0,0,1.
